fu_regfile: RTL

- Register file and operand-select stage directly upstream of the function unit in the mycpu datapath.
- Holds the general-purpose registers and drives the FU a/b operands. Port B can carry either a register or an immediate constant.
- Captures the FU result (or a memory load) on writeback.
- Latches the FU zero/negative flags into a status register for the branch logic.

---
 rtl/fu_regfile_if.sv | 37 +++
 rtl/fu_regfile.sv | 66 ++++++
 2 files changed

// File: rtl/fu_regfile_if.sv
// Operand/writeback bus between the decode stage and the register file.
// Reads are combinational, so the master sees outputs in the same cycle it drives addresses.
interface fu_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] aa_in;
  logic [ADDR_W-1:0] ba_in;
  logic [ADDR_W-1:0] da_in;
  logic              wr_en_in;
  logic              md_sel_in;
  logic [DATA_W-1:0] fu_f_in;
  logic [DATA_W-1:0] mem_d_in;
  logic              mb_sel_in;
  logic [DATA_W-1:0] const_in;
  logic              fu_z_in;
  logic              fu_n_in;
  logic              flag_en_in;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [DATA_W-1:0] addr_out;
  logic              z_out;
  logic              n_out;
  logic [15:0]       wr_cnt_out;

  modport master (
    output aa_in, ba_in, da_in, wr_en_in, md_sel_in, fu_f_in, mem_d_in,
           mb_sel_in, const_in, fu_z_in, fu_n_in, flag_en_in,
    input  a_out, b_out, addr_out, z_out, n_out, wr_cnt_out
  );

  modport slave (
    input  aa_in, ba_in, da_in, wr_en_in, md_sel_in, fu_f_in, mem_d_in,
           mb_sel_in, const_in, fu_z_in, fu_n_in, flag_en_in,
    output a_out, b_out, addr_out, z_out, n_out, wr_cnt_out
  );
endinterface

// File: rtl/fu_regfile.sv
// General-purpose register file with B-operand immediate mux, writeback source mux,
// FU status flags and a committed-write counter.
module fu_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  parameter int ADDR_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  fu_regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              z_q, z_d;
  logic              n_q, n_d;

  logic              aa_ok, ba_ok, da_ok;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign aa_ok = int'(bus.aa_in) < REG_N;
  assign ba_ok = int'(bus.ba_in) < REG_N;
  assign da_ok = int'(bus.da_in) < REG_N;

  // Reads come straight from the flops: no write bypass, which keeps the FU path loop-free.
  assign rd_a = aa_ok ? regs_q[bus.aa_in] : '0;
  assign rd_b = ba_ok ? regs_q[bus.ba_in] : '0;

  assign bus.a_out      = rd_a;
  assign bus.addr_out   = rd_a;
  assign bus.b_out      = bus.mb_sel_in ? bus.const_in : rd_b;
  assign bus.z_out      = z_q;
  assign bus.n_out      = n_q;
  assign bus.wr_cnt_out = wr_cnt_q;

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    z_d      = z_q;
    n_d      = n_q;
    if (bus.wr_en_in && da_ok) begin
      regs_d[bus.da_in] = bus.md_sel_in ? bus.mem_d_in : bus.fu_f_in;
      wr_cnt_d          = wr_cnt_q + 16'd1;
    end
    if (bus.flag_en_in) begin
      z_d = bus.fu_z_in;
      n_d = bus.fu_n_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
      wr_cnt_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

endmodule
